// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
// Shift-add multiply and restoring divide over 32 cycles, with stall request and registered result.
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        func3_in,
  input  logic [6:0]        func7_in,
  input  logic [XLEN-1:0]   rs1_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic              rd_en_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  output logic              stall_req,
  output logic              busy,
  output logic              result_valid,
  output logic [XLEN-1:0]   result,
  output logic              rd_en_out,
  output logic [REG_AW-1:0] rd_addr_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [5:0]          count;
  logic [XLEN-1:0]     op_q, acc_hi, acc_lo;
  logic [2:0]          f3_q;
  logic                neg_q, neg_r_q, rd_en_q, rd_en_done;
  logic [REG_AW-1:0]   rd_addr_q;
  logic                stall_c;

  logic                is_m, is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  always_comb begin
    is_m     = (opcode_in == 7'b0110011) && (func7_in == 7'b0000001);
    is_div   = func3_in[2];
    a_signed = is_div ? !func3_in[0] : (func3_in == 3'b001 || func3_in == 3'b010);
    b_signed = is_div ? !func3_in[0] : (func3_in == 3'b001);
    sa       = a_signed & rs1_in[XLEN-1];
    sb       = b_signed & rs2_in[XLEN-1];
    mag_a    = sa ? -rs1_in : rs1_in;
    mag_b    = sb ? -rs2_in : rs2_in;
    div_zero = is_div && (rs2_in == '0);
    div_ovf  = is_div && !func3_in[0] && (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
    special  = div_zero || div_ovf;
    // func3[1] selects the remainder flavour of the divide ops
    if (func3_in[1])
      special_res = div_zero ? rs1_in : '0;
    else
      special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_sh;
  logic                div_ok;
  logic [XLEN-1:0]     div_diff;
  logic [XLEN-1:0]     nxt_hi, nxt_lo;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, calc_res;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_q} : '0);
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_ok   = div_sh >= {1'b0, op_q};
    // the true difference is below the divisor, so 32 bits hold it exactly
    div_diff = div_sh[XLEN-1:0] - op_q;
    if (f3_q[2]) begin
      nxt_hi = div_ok ? div_diff : div_sh[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], div_ok};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod_s = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    quo_s  = neg_q ? -nxt_lo : nxt_lo;
    rem_s  = neg_r_q ? -nxt_hi : nxt_hi;
    if (f3_q[2])
      calc_res = f3_q[1] ? rem_s : quo_s;
    else
      calc_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (is_m && !flush) begin
          stall_c   = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
          if (count == 6'd1)
            state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    stall_req    = stall_c & ~rst;
    busy         = (state == CALC);
    result_valid = (state == DONE) && !flush;
    rd_en_out    = result_valid && rd_en_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_en_done  <= 1'b0;
      result      <= '0;
      rd_addr_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (is_m && !flush) begin
            f3_q      <= func3_in;
            rd_en_q   <= rd_en_in;
            rd_addr_q <= rd_addr_in;
            neg_q     <= sa ^ sb;
            neg_r_q   <= sa;
            if (special) begin
              result      <= special_res;
              rd_addr_out <= rd_addr_in;
              rd_en_done  <= rd_en_in;
            end else begin
              acc_hi <= '0;
              acc_lo <= is_div ? mag_a : mag_b;
              op_q   <= is_div ? mag_b : mag_a;
              count  <= 6'd32;
            end
          end
        end
        CALC: begin
          if (flush) begin
            count <= '0;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            count  <= count - 6'd1;
            if (count == 6'd1) begin
              result      <= calc_res;
              rd_addr_out <= rd_addr_q;
              rd_en_done  <= rd_en_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
// Random and directed M-ops checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [6:0]  opcode_in, func7_in;
  logic [2:0]  func3_in;
  logic [31:0] rs1_in, rs2_in;
  logic        rd_en_in;
  logic [4:0]  rd_addr_in;
  logic        stall_req, busy, result_valid, rd_en_out;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .opcode_in(opcode_in), .func3_in(func3_in), .func7_in(func7_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
    .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    r  = '0;
    p  = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = ia / ib;
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = ia % ib;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic drive_nop();
    opcode_in = 7'h13; func7_in = 7'h0; func3_in = 3'h0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rden,
                        output int vcyc, output int scnt, output logic [31:0] res,
                        output logic [4:0] rdo, output logic rdeno);
    @(posedge clk); #1;
    opcode_in = 7'b0110011; func7_in = 7'b0000001; func3_in = f3;
    rs1_in = a; rs2_in = b; rd_addr_in = rd; rd_en_in = rden;
    #1;
    vcyc = -1; scnt = 0; res = '0; rdo = '0; rdeno = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (stall_req) scnt++;
      if (result_valid) begin
        vcyc = c; res = result; rdo = rd_addr_out; rdeno = rd_en_out;
        break;
      end
      @(posedge clk); #1;
      rs1_in = $urandom; rs2_in = $urandom;
      #1;
    end
    drive_nop();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    opcode_in = 7'b0110011; func7_in = 7'b0000001; func3_in = 3'd0;
    rs1_in = 32'd3; rs2_in = 32'd4; rd_en_in = 1'b1; rd_addr_in = 5'd3;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall_req); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if ({rd_en_out, rd_addr_out} !== 6'h0) begin errors++; $display("FAIL reset_rd got=%b/%h want=0/0", rd_en_out, rd_addr_out); end
    drive_nop();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    int v, s; logic [31:0] r; logic [4:0] ra; logic re;
    run_op(3'd0, 32'd7, 32'd6, 5'd9, 1'b1, v, s, r, ra, re);
    checks++; if (v !== 33) begin errors++; $display("FAIL mul_basic_latency got=%0d want=33", v); end
    checks++; if (s !== 33) begin errors++; $display("FAIL mul_basic_stall_cycles got=%0d want=33", s); end
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL mul_basic_result got=%h want=%h", r, 32'd42); end
    checks++; if (ra !== 5'd9) begin errors++; $display("FAIL mul_basic_rd_addr got=%h want=9", ra); end
    checks++; if (re !== 1'b1) begin errors++; $display("FAIL mul_basic_rd_en got=%b want=1", re); end
  endtask

  task automatic test_table(input int kind);
    logic [2:0]  tf[4];
    logic [31:0] ta[4], tb[4], tr[4];
    int v, s, want_lat, n; logic [31:0] r; logic [4:0] ra; logic re;
    if (kind == 0) begin
      n = 3;
      tf = '{3'd1, 3'd3, 3'd2, 3'd0};
      ta = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
      tb = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'h0};
      tr = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    end else if (kind == 1) begin
      n = 4;
      tf = '{3'd4, 3'd6, 3'd5, 3'd7};
      ta = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      tb = '{32'd2, 32'd2, 32'd2, 32'd2};
      tr = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
    end else begin
      n = 4;
      tf = '{3'd4, 3'd6, 3'd4, 3'd6};
      ta = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      tb = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tr = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    end
    want_lat = (kind == 2) ? 1 : 33;
    for (int i = 0; i < n; i++) begin
      run_op(tf[i], ta[i], tb[i], 5'(i + 4), 1'b1, v, s, r, ra, re);
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL table%0d_result[%0d] got=%h want=%h", kind, i, r, tr[i]); end
      checks++; if (v !== want_lat) begin errors++; $display("FAIL table%0d_latency[%0d] got=%0d want=%0d", kind, i, v, want_lat); end
      checks++; if (s !== want_lat) begin errors++; $display("FAIL table%0d_stall_cycles[%0d] got=%0d want=%0d", kind, i, s, want_lat); end
    end
  endtask

  task automatic test_output_hold();
    int v, s; logic [31:0] r; logic [4:0] ra; logic re;
    run_op(3'd5, 32'd7, 32'd2, 5'd21, 1'b1, v, s, r, ra, re);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (result !== 32'd3) begin errors++; $display("FAIL hold_result got=%h want=3", result); end
    checks++; if (rd_addr_out !== 5'd21) begin errors++; $display("FAIL hold_rd_addr got=%h want=15", rd_addr_out); end
    checks++; if ({result_valid, rd_en_out} !== 2'b00) begin errors++; $display("FAIL hold_valid got=%b want=00", {result_valid, rd_en_out}); end
  endtask

  task automatic test_non_m();
    int seen;
    @(posedge clk); #1;
    opcode_in = 7'b0110011; func7_in = 7'h0; func3_in = 3'd0;
    rs1_in = 32'd1; rs2_in = 32'd2;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall_req || result_valid || busy) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL non_m_activity got=%0d want=0", seen); end
    drive_nop();
  endtask

  task automatic test_back_to_back();
    int v1, v2, s; logic [31:0] r1, r2; logic [4:0] ra; logic re;
    run_op(3'd0, 32'd3, 32'd4, 5'd1, 1'b1, v1, s, r1, ra, re);
    run_op(3'd0, 32'd5, 32'd5, 5'd17, 1'b1, v2, s, r2, ra, re);
    checks++; if (v1 !== 33) begin errors++; $display("FAIL b2b_first_cycle got=%0d want=33", v1); end
    checks++; if (v1 + 1 + v2 !== 67) begin errors++; $display("FAIL b2b_second_cycle got=%0d want=67", v1 + 1 + v2); end
    checks++; if (r1 !== 32'd12) begin errors++; $display("FAIL b2b_first_result got=%h want=c", r1); end
    checks++; if (r2 !== 32'd25) begin errors++; $display("FAIL b2b_second_result got=%h want=19", r2); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    opcode_in = 7'b0110011; func7_in = 7'b0000001; func3_in = 3'd4;
    rs1_in = 32'd100; rs2_in = 32'd7; rd_addr_in = 5'd12; rd_en_in = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b want=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, stall_req, result_valid, rd_en_out} !== 4'b0) begin errors++; $display("FAIL areset_ctrl got=%b want=0000", {busy, stall_req, result_valid, rd_en_out}); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result got=%h want=0", result); end
    checks++; if (rd_addr_out !== 5'h0) begin errors++; $display("FAIL areset_rd_addr got=%h want=0", rd_addr_out); end
    drive_nop();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_post_busy got=%b want=0", busy); end
  endtask

  task automatic test_flush();
    int seen;
    @(posedge clk); #1;
    opcode_in = 7'b0110011; func7_in = 7'b0000001; func3_in = 3'd0;
    rs1_in = 32'd7; rs2_in = 32'd6; rd_addr_in = 5'd2; rd_en_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_c10 got=%b want=1", busy); end
    @(posedge clk); #1;
    flush = 1'b0; drive_nop();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_c11 got=%b want=0", busy); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) seen++;
      @(posedge clk); #2;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got=%0d want=0", seen); end
  endtask

  task automatic test_flush_done();
    @(posedge clk); #1;
    opcode_in = 7'b0110011; func7_in = 7'b0000001; func3_in = 3'd4;
    rs1_in = 32'd5; rs2_in = 32'd0; rd_addr_in = 5'd8; rd_en_in = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1; drive_nop();
    #1;
    checks++; if ({result_valid, rd_en_out} !== 2'b00) begin errors++; $display("FAIL flush_done_valid got=%b want=00", {result_valid, rd_en_out}); end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_random();
    int v, s, want_lat; logic [31:0] r, a, b, want; logic [4:0] ra, rd; logic re, rden; logic [2:0] f3;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: b = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      rd = 5'($urandom); rden = 1'($urandom);
      want = ref_res(f3, a, b);
      want_lat = is_special(f3, a, b) ? 1 : 33;
      run_op(f3, a, b, rd, rden, v, s, r, ra, re);
      checks++; if (r !== want) begin errors++; $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, r, want); end
      checks++; if (v !== want_lat || s !== want_lat) begin errors++; $display("FAIL rand_timing[%0d] got=%0d/%0d want=%0d", i, v, s, want_lat); end
      checks++; if ({ra, re} !== {rd, rden}) begin errors++; $display("FAIL rand_rd[%0d] got=%h/%b want=%h/%b", i, ra, re, rd, rden); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_table(0);
    test_table(1);
    test_table(2);
    test_output_hold();
    test_non_m();
    test_back_to_back();
    test_async_reset();
    test_flush();
    test_flush_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
